// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-to-1 valid/ready stream mux, external select or round-robin.
// Define STREAM_MUX_PARITY_EN to add the registered even-parity output out_par.
module stream_mux_nx1 #(
    parameter int  N    = 4,
    parameter int  W    = 8,
    parameter int  MODE = 0,
    localparam int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_ch
`ifdef STREAM_MUX_PARITY_EN
    ,
    output logic           out_par
`endif
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("stream_mux_nx1: N must be in 2..16");
    end
    if (W < 1 || W > 64) begin : g_bad_w
        $error("stream_mux_nx1: W must be in 1..64");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("stream_mux_nx1: MODE must be 0 or 1");
    end

    logic [N-1:0]  grant;
    logic [SW-1:0] gnt_idx;
    logic [W-1:0]  gnt_data;
    logic          load_en;
    logic          xfer;

    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] ch_q, ch_d;

    // Output register can take a word when empty or being drained this edge.
    assign load_en  = ~valid_q | out_ready;
    assign in_ready = grant & {N{load_en}};
    assign xfer     = |(in_valid & in_ready);

    if (MODE == 0) begin : g_ext
        always_comb begin
            grant   = '0;
            gnt_idx = sel;
            for (int k = 0; k < N; k++) begin
                if (sel == SW'(k)) begin
                    grant[k] = 1'b1;
                end
            end
        end
    end else begin : g_rr
        logic [SW-1:0] ptr_q, ptr_d;
        logic          sel_unused;

        assign sel_unused = ^sel;

        // Search starts one past the last granted channel, wrapping at N.
        always_comb begin
            logic found;
            found   = 1'b0;
            grant   = '0;
            gnt_idx = '0;
            for (int i = 1; i <= N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && in_valid[k] &&
                        (k == (int'(ptr_q) + i) % N)) begin
                        found    = 1'b1;
                        grant[k] = 1'b1;
                        gnt_idx  = SW'(k);
                    end
                end
            end
        end

        assign ptr_d = xfer ? gnt_idx : ptr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_q <= SW'(N - 1);
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                gnt_data = in_data[k*W +: W];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        if (load_en) begin
            valid_d = xfer;
            if (xfer) begin
                data_d = gnt_data;
                ch_d   = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

`ifdef STREAM_MUX_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (load_en && xfer) begin
            par_d = ^gnt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_par = par_q;
`else
`endif

endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb_stream_mux_nx1: three mux instances (ext N=4, rr N=4, ext N=3)
// checked every cycle against a transaction-level model.
module tb_stream_mux_nx1;

    logic        clk;
    logic        rst_n;

    logic [31:0] d0, d1;
    logic [23:0] d2;
    logic [3:0]  v0, v1;
    logic [2:0]  v2;
    logic [1:0]  s0, s1, s2;
    logic        r0, r1, r2;

    logic [3:0]  ir0, ir1;
    logic [2:0]  ir2;
    logic [7:0]  od0, od1, od2;
    logic        ov0, ov1, ov2;
    logic [1:0]  oc0, oc1, oc2;
`ifdef STREAM_MUX_PARITY_EN
    logic        op0, op1, op2;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic       mv[3];
    logic [7:0] md[3];
    int         mc[3];
    int         mptr[3];

    stream_mux_nx1 #(.N(4), .W(8), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d0), .in_valid(v0), .in_ready(ir0), .sel(s0),
        .out_data(od0), .out_valid(ov0), .out_ready(r0), .out_ch(oc0)
`ifdef STREAM_MUX_PARITY_EN
        , .out_par(op0)
`endif
    );

    stream_mux_nx1 #(.N(4), .W(8), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d1), .in_valid(v1), .in_ready(ir1), .sel(s1),
        .out_data(od1), .out_valid(ov1), .out_ready(r1), .out_ch(oc1)
`ifdef STREAM_MUX_PARITY_EN
        , .out_par(op1)
`endif
    );

    stream_mux_nx1 #(.N(3), .W(8), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d2), .in_valid(v2), .in_ready(ir2), .sel(s2),
        .out_data(od2), .out_valid(ov2), .out_ready(r2), .out_ch(oc2)
`ifdef STREAM_MUX_PARITY_EN
        , .out_par(op2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nch(int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic int modei(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic logic [31:0] fdat(int i);
        case (i)
            0:       return d0;
            1:       return d1;
            default: return {8'h00, d2};
        endcase
    endfunction

    function automatic logic [3:0] fval(int i);
        case (i)
            0:       return v0;
            1:       return v1;
            default: return {1'b0, v2};
        endcase
    endfunction

    function automatic int fsel(int i);
        case (i)
            0:       return int'(s0);
            1:       return int'(s1);
            default: return int'(s2);
        endcase
    endfunction

    function automatic logic frdy(int i);
        case (i)
            0:       return r0;
            1:       return r1;
            default: return r2;
        endcase
    endfunction

    function automatic logic [3:0] fir(int i);
        case (i)
            0:       return ir0;
            1:       return ir1;
            default: return {1'b0, ir2};
        endcase
    endfunction

    function automatic logic [7:0] fod(int i);
        case (i)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

    function automatic logic fov(int i);
        case (i)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic int foc(int i);
        case (i)
            0:       return int'(oc0);
            1:       return int'(oc1);
            default: return int'(oc2);
        endcase
    endfunction

`ifdef STREAM_MUX_PARITY_EN
    function automatic logic fop(int i);
        case (i)
            0:       return op0;
            1:       return op1;
            default: return op2;
        endcase
    endfunction
`endif

    // Channel the rules grant right now, -1 when none.
    function automatic int pick(int i);
        logic [3:0] v;
        int         idx;
        v = fval(i);
        if (modei(i) == 0) begin
            return (fsel(i) < nch(i)) ? fsel(i) : -1;
        end
        for (int j = 1; j <= nch(i); j++) begin
            idx = (mptr[i] + j) % nch(i);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(int i);
        int   g;
        logic le;
        g  = pick(i);
        le = !mv[i] || frdy(i);
        if (g >= 0 && le) return 4'(1 << g);
        return 4'b0000;
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[u%0d] t=%0t: got %0h expected %0h",
                     nm, i, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mv[i]   <= 1'b0;
                md[i]   <= 8'h00;
                mc[i]   <= 0;
                mptr[i] <= nch(i) - 1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int         g;
                logic       le;
                logic       x;
                logic [3:0] vv;
                g  = pick(i);
                vv = fval(i);
                le = !mv[i] || frdy(i);
                x  = le && (g >= 0) && vv[g];
                if (le) mv[i] <= x;
                if (x) begin
                    md[i] <= 8'(fdat(i) >> (8 * g));
                    mc[i] <= g;
                    if (modei(i) == 1) mptr[i] <= g;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk("rst_valid", i, 64'(fov(i)), 64'(0));
                chk("rst_data", i, 64'(fod(i)), 64'(0));
                chk("rst_ch", i, 64'(foc(i)), 64'(0));
`ifdef STREAM_MUX_PARITY_EN
                chk("rst_par", i, 64'(fop(i)), 64'(0));
`endif
            end else begin
                chk("in_ready", i, 64'(fir(i)), 64'(exp_rdy(i)));
                chk("out_valid", i, 64'(fov(i)), 64'(mv[i]));
                if (mv[i]) begin
                    chk("out_data", i, 64'(fod(i)), 64'(md[i]));
                    chk("out_ch", i, 64'(foc(i)), 64'(mc[i]));
`ifdef STREAM_MUX_PARITY_EN
                    chk("out_par", i, 64'(fop(i)), 64'(^md[i]));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         seq_ch[5]  = '{0, 1, 2, 3, 0};
    logic [7:0] seq_dat[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        rst_n = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        v0 = '0; v1 = '0; v2 = '0;
        s0 = '0; s1 = '0; s2 = '0;
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        tick();
        tick();
        chk("lit_rst_valid", 0, 64'(ov0), 64'(0));
        chk("lit_rst_data", 0, 64'(od0), 64'(0));
        chk("lit_rst_ch", 1, 64'(oc1), 64'(0));
        rst_n = 1'b1;
        tick();

        // External select, single word on ch2
        s0 = 2'd2; d0 = 32'h11A52233; v0 = 4'b0100; r0 = 1'b1;
        tick();
        chk("lit_a5_data", 0, 64'(od0), 64'hA5);
        chk("lit_a5_ch", 0, 64'(oc0), 64'd2);
        chk("lit_a5_valid", 0, 64'(ov0), 64'd1);
`ifdef STREAM_MUX_PARITY_EN
        chk("lit_a5_par", 0, 64'(op0), 64'd0);
`endif
        v0 = 4'b0000;
        tick();
        chk("lit_drain_valid", 0, 64'(ov0), 64'd0);

        // Hold under backpressure while sel and data wander
        d0 = 32'h113C2233; v0 = 4'b0100; r0 = 1'b0;
        tick();
        chk("lit_hold_load", 0, 64'(od0), 64'h3C);
        chk("lit_hold_rdy", 0, 64'(ir0), 64'd0);
        for (int j = 0; j < 3; j++) begin
            s0 = 2'(j);
            d0 = 32'hDEADBEEF + 32'(j);
            v0 = 4'b1111;
            tick();
            chk("lit_hold_data", 0, 64'(od0), 64'h3C);
            chk("lit_hold_ch", 0, 64'(oc0), 64'd2);
        end
        s0 = 2'd1; d0 = 32'h00005A00; v0 = 4'b0010; r0 = 1'b1;
        tick();
        chk("lit_replace_data", 0, 64'(od0), 64'h5A);
        chk("lit_replace_ch", 0, 64'(oc0), 64'd1);
        chk("lit_replace_valid", 0, 64'(ov0), 64'd1);
        v0 = 4'b0000;
        tick();

        // N=3 with out-of-range select
        d2 = 24'h000077; v2 = 3'b001; s2 = 2'd0; r2 = 1'b0;
        tick();
        chk("lit_n3_data", 2, 64'(od2), 64'h77);
        s2 = 2'd3; v2 = 3'b111;
        tick();
        chk("lit_n3_rdy", 2, 64'(ir2), 64'd0);
        chk("lit_n3_hold", 2, 64'(ov2), 64'd1);
        r2 = 1'b1;
        tick();
        chk("lit_n3_drain", 2, 64'(ov2), 64'd0);
        chk("lit_n3_rdy2", 2, 64'(ir2), 64'd0);
        v2 = 3'b000;

        // Round-robin over all four channels
        d1 = 32'h44332211; v1 = 4'b1111; r1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("lit_rr_ch", 1, 64'(oc1), 64'(seq_ch[k]));
            chk("lit_rr_data", 1, 64'(od1), 64'(seq_dat[k]));
        end
        v1 = 4'b1001;
        tick();
        chk("lit_rr_skip3", 1, 64'(oc1), 64'd3);
        tick();
        chk("lit_rr_wrap0", 1, 64'(oc1), 64'd0);
        v1 = 4'b0000;
        tick();

        // Round-robin pointer holds while stalled
        r1 = 1'b0; v1 = 4'b0110;
        tick();
        chk("lit_rr_stall_ch", 1, 64'(oc1), 64'd1);
        tick();
        tick();
        chk("lit_rr_stall_hold", 1, 64'(oc1), 64'd1);
        r1 = 1'b1;
        tick();
        chk("lit_rr_resume_ch", 1, 64'(oc1), 64'd2);
        chk("lit_rr_resume_data", 1, 64'(od1), 64'h33);

        // Asynchronous reset mid-stream
        v1 = 4'b1111;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_arst_valid", 1, 64'(ov1), 64'd0);
        chk("lit_arst_data", 1, 64'(od1), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("lit_restart_ch0", 1, 64'(oc1), 64'd0);
        chk("lit_restart_valid", 1, 64'(ov1), 64'd1);
        tick();
        chk("lit_restart_ch1", 1, 64'(oc1), 64'd1);
        v1 = 4'b0000;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
